mips_ni_controller: RTL and testbench

//  Sequences word transfers between the pipelined MIPS core and its NoC router port.
//  TX: captures the EX-stage send request (proc_valid/dest/NI_in) into a holding

---
 rtl/mips_ni_controller_pkg.sv | 25 ++
 rtl/mips_ni_controller_if.sv | 31 +++
 rtl/ni_sync_fifo.sv | 61 ++++++
 rtl/mips_ni_controller.sv | 144 ++++++++++++++
 tb/tb_mips_ni_controller.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_ni_controller_pkg.sv
// Shared types and defaults for the MIPS network-interface controller and
// the router-side logic that reuses its FIFO.
package mips_ni_controller_pkg;

  // Defaults match the core datapath and a 4-node mesh.
  localparam int NI_DATA_W = 32;
  localparam int NI_ADDR_W = 2;

  typedef enum logic {
    T_IDLE,
    T_SEND
  } tx_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DELIVER
  } rx_state_t;

  // Occupancy counter width: one extra bit so "full" is distinguishable from "empty".
  function automatic int ni_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mips_ni_controller_if.sv
// Router link between the network interface (master) and the NoC router port (slave).
interface mips_ni_controller_if
  import mips_ni_controller_pkg::*;
#(
  parameter int DATA_W = NI_DATA_W,
  parameter int ADDR_W = NI_ADDR_W
);

  // TX direction: NI -> router
  logic              pkt_out_valid;
  logic [ADDR_W-1:0] pkt_out_dest;
  logic [ADDR_W-1:0] pkt_out_src;
  logic [DATA_W-1:0] pkt_out_data;
  logic              pkt_out_ready;

  // RX direction: router -> NI
  logic              pkt_in_valid;
  logic [DATA_W-1:0] pkt_in_data;
  logic              pkt_in_ready;

  modport master (
    output pkt_out_valid, pkt_out_dest, pkt_out_src, pkt_out_data, pkt_in_ready,
    input  pkt_out_ready, pkt_in_valid, pkt_in_data
  );

  modport slave (
    input  pkt_out_valid, pkt_out_dest, pkt_out_src, pkt_out_data, pkt_in_ready,
    output pkt_out_ready, pkt_in_valid, pkt_in_data
  );

endinterface

// File: rtl/ni_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; no write-to-read bypass,
// so a word pushed in one cycle is visible at the output from the next.
module ni_sync_fifo
  import mips_ni_controller_pkg::*;
#(
  parameter int WIDTH = NI_DATA_W,
  parameter int DEPTH = 4            // power of two, >= 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [ni_cnt_w(DEPTH)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = ni_cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_reg == CNT_W'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr_reg];

  // Storage array: written only on accepted pushes, never reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mips_ni_controller.sv
// Network interface between the pipelined MIPS core and its NoC router port:
// a one-entry TX holding register with valid/ready, and an RX FIFO feeding
// one word per core receive request.
module mips_ni_controller
  import mips_ni_controller_pkg::*;
#(
  parameter int DATA_W   = NI_DATA_W,
  parameter int ADDR_W   = NI_ADDR_W,
  parameter int NODE_ID  = 0,
  parameter int RX_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                proc_valid,
  input  logic [ADDR_W-1:0]   dest_add,
  input  logic [DATA_W-1:0]   NI_in,
  input  logic                proc_ready_in,
  output logic                mips_ni,
  output logic                data_valid,
  output logic [DATA_W-1:0]   wd_NI,
  output logic                tx_busy,
  output logic                tx_overflow,
  mips_ni_controller_if.master router
);

  localparam int CNT_W = ni_cnt_w(RX_DEPTH);

  tx_state_t         tx_state_reg, tx_state_next;
  logic [ADDR_W-1:0] tx_dest_reg;
  logic [DATA_W-1:0] tx_data_reg;
  logic              tx_overflow_reg;

  rx_state_t         rx_state_reg, rx_state_next;
  logic [DATA_W-1:0] wd_reg;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_pop_data;
  logic [CNT_W-1:0]  rx_count_unused;   // occupancy only needed by router-side users

  ni_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (router.pkt_in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (rx_count_unused)
  );

  assign fifo_push   = router.pkt_in_valid && !fifo_full;
  assign wd_NI       = wd_reg;
  assign tx_overflow = tx_overflow_reg;

  // ---------------- TX ----------------

  // TX state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state_reg <= T_IDLE;
    else        tx_state_reg <= tx_state_next;
  end

  // TX next state: acceptance returns to idle; no reload in the same cycle.
  always_comb begin
    tx_state_next = tx_state_reg;
    case (tx_state_reg)
      T_IDLE:  if (proc_valid)           tx_state_next = T_SEND;
      T_SEND:  if (router.pkt_out_ready) tx_state_next = T_IDLE;
      default:                           tx_state_next = T_IDLE;
    endcase
  end

  // TX outputs: valid/dest/data come straight from the holding register.
  always_comb begin
    tx_busy              = (tx_state_reg == T_SEND);
    router.pkt_out_valid = (tx_state_reg == T_SEND);
    router.pkt_out_dest  = tx_dest_reg;
    router.pkt_out_data  = tx_data_reg;
    router.pkt_out_src   = ADDR_W'(NODE_ID);
  end

  // TX holding register capture and sticky overflow on a send while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_dest_reg     <= '0;
      tx_data_reg     <= '0;
      tx_overflow_reg <= 1'b0;
    end else if (proc_valid) begin
      if (tx_state_reg == T_IDLE) begin
        tx_dest_reg <= dest_add;
        tx_data_reg <= NI_in;
      end else begin
        tx_overflow_reg <= 1'b1;
      end
    end
  end

  // ---------------- RX ----------------

  // RX state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state_reg <= R_IDLE;
    else        rx_state_reg <= rx_state_next;
  end

  // RX next state: a waiting request that is withdrawn aborts rather than
  // delivering a word the core no longer expects.
  always_comb begin
    rx_state_next = rx_state_reg;
    case (rx_state_reg)
      R_IDLE: begin
        if (proc_ready_in) rx_state_next = fifo_empty ? R_WAIT : R_DELIVER;
      end
      R_WAIT: begin
        if (!proc_ready_in)   rx_state_next = R_IDLE;
        else if (!fifo_empty) rx_state_next = R_DELIVER;
      end
      R_DELIVER: rx_state_next = R_IDLE;
      default:   rx_state_next = R_IDLE;
    endcase
  end

  // RX outputs: stall while waiting or delivering; pop when a request meets data.
  always_comb begin
    mips_ni             = (rx_state_reg != R_IDLE);
    data_valid          = (rx_state_reg == R_DELIVER);
    fifo_pop            = (rx_state_reg != R_DELIVER) && proc_ready_in && !fifo_empty;
    router.pkt_in_ready = !fifo_full;
  end

  // Delivered-word register: loads on pop, holds the last word otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        wd_reg <= '0;
    else if (fifo_pop) wd_reg <= fifo_pop_data;
  end

endmodule

// File: tb/tb_mips_ni_controller.sv
// Scoreboard bench for mips_ni_controller: stimulus pushes expected TX packets
// and RX words into queues; a negedge monitor pops and compares on handshakes.
module tb_mips_ni_controller;

  localparam int DW    = 32;
  localparam int AW    = 2;
  localparam int NODE  = 1;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [AW-1:0] dest;
    logic [AW-1:0] src;
    logic [DW-1:0] data;
  } tx_exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          proc_valid;
  logic [AW-1:0] dest_add;
  logic [DW-1:0] NI_in;
  logic          proc_ready_in;
  logic          mips_ni;
  logic          data_valid;
  logic [DW-1:0] wd_NI;
  logic          tx_busy;
  logic          tx_overflow;

  int n_cmp = 0;
  int n_err = 0;

  tx_exp_t       tx_q[$];
  logic [DW-1:0] rx_q[$];

  mips_ni_controller_if #(.DATA_W(DW), .ADDR_W(AW)) rif ();

  mips_ni_controller #(
    .DATA_W(DW), .ADDR_W(AW), .NODE_ID(NODE), .RX_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .proc_valid    (proc_valid),
    .dest_add      (dest_add),
    .NI_in         (NI_in),
    .proc_ready_in (proc_ready_in),
    .mips_ni       (mips_ni),
    .data_valid    (data_valid),
    .wd_NI         (wd_NI),
    .tx_busy       (tx_busy),
    .tx_overflow   (tx_overflow),
    .router        (rif)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string pfx);
    check({pfx, "_mips_ni"},      32'(mips_ni),            0);
    check({pfx, "_data_valid"},   32'(data_valid),         0);
    check({pfx, "_wd_NI"},        wd_NI,                   0);
    check({pfx, "_tx_busy"},      32'(tx_busy),            0);
    check({pfx, "_tx_overflow"},  32'(tx_overflow),        0);
    check({pfx, "_pkt_valid"},    32'(rif.pkt_out_valid),  0);
    check({pfx, "_pkt_dest"},     32'(rif.pkt_out_dest),   0);
    check({pfx, "_pkt_data"},     rif.pkt_out_data,        0);
    check({pfx, "_fifo_empty"},   32'(rif.pkt_in_ready),   1);
  endtask

  // Single-cycle send request; optionally records the packet the router should see.
  task automatic send(input logic [AW-1:0] d, input logic [DW-1:0] x, input bit expect_it);
    @(posedge clk); #1;
    proc_valid = 1'b1; dest_add = d; NI_in = x;
    if (expect_it) tx_q.push_back({d, AW'(NODE), x});
    @(posedge clk); #1;
    proc_valid = 1'b0;
  endtask

  // One-cycle router delivery; assumes pkt_in_ready is high.
  task automatic push_word(input logic [DW-1:0] x, input bit expect_it);
    @(posedge clk); #1;
    rif.pkt_in_valid = 1'b1; rif.pkt_in_data = x;
    if (expect_it) rx_q.push_back(x);
    @(posedge clk); #1;
    rif.pkt_in_valid = 1'b0;
  endtask

  // Counts negedges until data_valid (0 on timeout), then withdraws the request.
  task automatic wait_deliver(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (data_valid) begin
        cyc = i;
        break;
      end
    end
    proc_ready_in = 1'b0;
  endtask

  // Monitor: compares every accepted TX packet and every delivered RX word.
  initial begin : monitor
    tx_exp_t       e;
    logic [DW-1:0] w;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (rif.pkt_out_valid && rif.pkt_out_ready) begin
          if (tx_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL tx_unexpected: got dest=%0d data=%h expected no packet",
                     rif.pkt_out_dest, rif.pkt_out_data);
          end else begin
            e = tx_q.pop_front();
            check("tx_dest", 32'(rif.pkt_out_dest), 32'(e.dest));
            check("tx_src",  32'(rif.pkt_out_src),  32'(e.src));
            check("tx_data", rif.pkt_out_data,      e.data);
            $display("tx packet dest=%0d src=%0d data=%h", rif.pkt_out_dest,
                     rif.pkt_out_src, rif.pkt_out_data);
          end
        end
        if (data_valid) begin
          if (rx_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL rx_unexpected: got wd_NI=%h expected no delivery", wd_NI);
          end else begin
            w = rx_q.pop_front();
            check("rx_word", wd_NI, w);
            $display("rx delivery wd_NI=%h", wd_NI);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

  initial begin : stim
    int cyc;
    rst_n = 1'b0; proc_valid = 1'b0; dest_add = '0; NI_in = '0; proc_ready_in = 1'b0;
    rif.pkt_out_ready = 1'b0; rif.pkt_in_valid = 1'b0; rif.pkt_in_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;

    // Send with router ready: valid one cycle after request, then idle
    rif.pkt_out_ready = 1'b1;
    send(2'd2, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk);
    check("send_busy",  32'(tx_busy),           1);
    check("send_valid", 32'(rif.pkt_out_valid), 1);
    @(negedge clk);
    check("send_done_busy",  32'(tx_busy),           0);
    check("send_done_valid", 32'(rif.pkt_out_valid), 0);

    // Backpressure: outputs stable, second request dropped and flagged
    rif.pkt_out_ready = 1'b0;
    send(2'd1, 32'hA5A5_0001, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", 32'(rif.pkt_out_valid), 1);
      check("bp_dest",  32'(rif.pkt_out_dest),  1);
      check("bp_data",  rif.pkt_out_data,       32'hA5A5_0001);
    end
    check("bp_no_overflow_yet", 32'(tx_overflow), 0);
    send(2'd3, 32'h0BAD_0BAD, 1'b0);
    @(negedge clk);
    check("ovf_set",  32'(tx_overflow),      1);
    check("ovf_dest", 32'(rif.pkt_out_dest), 1);
    check("ovf_data", rif.pkt_out_data,      32'hA5A5_0001);
    @(posedge clk); #1;
    rif.pkt_out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_done_busy", 32'(tx_busy),     0);
    check("ovf_sticky",   32'(tx_overflow), 1);

    // Receive with data already buffered
    push_word(32'h0000_1234, 1'b1);
    proc_ready_in = 1'b1;
    wait_deliver(cyc);
    check("rx_latency", 32'(cyc), 2);
    check("rx_stall",   32'(mips_ni), 1);

    // Stall on empty FIFO until a word arrives
    @(posedge clk); #1;
    proc_ready_in = 1'b1;
    repeat (3) @(negedge clk);
    check("stall_mips_ni",    32'(mips_ni),    1);
    check("stall_data_valid", 32'(data_valid), 0);
    push_word(32'h0000_0055, 1'b1);
    wait_deliver(cyc);
    check("stall_latency", 32'(cyc), 2);

    // Fill to capacity, hold one extra word at the router, then drain in order
    for (int k = 0; k < DEPTH; k++) push_word(32'hF000_0000 + 32'(k), 1'b1);
    @(negedge clk);
    check("full_ready", 32'(rif.pkt_in_ready), 0);
    @(posedge clk); #1;
    rif.pkt_in_valid = 1'b1; rif.pkt_in_data = 32'hF000_0004;
    rx_q.push_back(32'hF000_0004);
    repeat (2) @(negedge clk);
    check("full_hold_ready", 32'(rif.pkt_in_ready), 0);
    @(posedge clk); #1;
    proc_ready_in = 1'b1;
    wait_deliver(cyc);
    check("full_pop_latency", 32'(cyc), 2);
    check("pop_frees_ready",  32'(rif.pkt_in_ready), 1);
    @(posedge clk); #1;
    rif.pkt_in_valid = 1'b0;
    @(negedge clk);
    check("refull_ready", 32'(rif.pkt_in_ready), 0);
    for (int k = 0; k < DEPTH; k++) begin
      @(posedge clk); #1;
      proc_ready_in = 1'b1;
      wait_deliver(cyc);
      check("drain_latency", 32'(cyc), 2);
    end
    @(negedge clk);
    check("drained_ready", 32'(rif.pkt_in_ready), 1);

    // Reset during T_SEND with RX words buffered
    rif.pkt_out_ready = 1'b0;
    push_word(32'hAAAA_0001, 1'b0);
    push_word(32'hAAAA_0002, 1'b0);
    send(2'd0, 32'hC0FF_EE00, 1'b0);
    @(negedge clk);
    check("pre_rst1_busy", 32'(tx_busy), 1);
    #2 rst_n = 1'b0;
    #1 check_idle("rst1");
    @(posedge clk); #1;
    rst_n = 1'b1;
    proc_ready_in = 1'b1;
    repeat (3) @(negedge clk);
    check("rst1_fifo_cleared_wait", 32'(mips_ni),    1);
    check("rst1_fifo_cleared_dv",   32'(data_valid), 0);

    // Reset during T_SEND and R_WAIT together
    send(2'd3, 32'h1111_2222, 1'b0);
    @(negedge clk);
    check("pre_rst2_busy",  32'(tx_busy), 1);
    check("pre_rst2_stall", 32'(mips_ni), 1);
    #2 rst_n = 1'b0;
    #1 check_idle("rst2");
    proc_ready_in = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("post_rst");

    check("tx_queue_drained", 32'(tx_q.size()), 0);
    check("rx_queue_drained", 32'(rx_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
